// File: rtl/tv_recorder.sv
// tv_recorder: captures a stream of W-bit test-vector records into an
// on-chip buffer, then plays them back in capture order over a valid/ready
// stream with the final record flagged by out_last.
module tv_recorder #(
  parameter int W     = 5,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       cap_valid,
  input  logic [W-1:0]               cap_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  output logic                       busy,
  output logic                       done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DUMP    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          overflow_r;
  logic          overflow_nxt_s;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic          wr_en_s;
  logic [PW-1:0] wr_addr_s;
  logic          full_s;
  logic          last_s;
  logic [CW-1:0] last_idx_s;

  // Buffer storage is intentionally never cleared; only pointers and flags are.
  logic [W-1:0]  mem_r [DEPTH];

  assign full_s     = (count_r == CW'(DEPTH));
  assign last_idx_s = count_r - CW'(1);
  assign last_s     = (state_r == S_DUMP) && (CW'(rd_ptr_r) == last_idx_s);

  assign out_valid = (state_r == S_DUMP);
  assign out_data  = mem_r[rd_ptr_r];
  assign out_last  = last_s;
  assign count     = count_r;
  assign full      = full_s;
  assign overflow  = overflow_r;
  assign busy      = (state_r == S_CAPTURE) || (state_r == S_DUMP);
  assign done      = (state_r == S_DONE);

  // Next-state, counter, pointer and buffer-write decode for every state.
  always_comb begin
    state_nxt_s    = state_r;
    count_nxt_s    = count_r;
    overflow_nxt_s = overflow_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    wr_en_s        = 1'b0;
    wr_addr_s      = count_r[PW-1:0];
    case (state_r)
      S_IDLE, S_DONE: begin
        // start wins over a simultaneous stop; stop alone is ignored here.
        if (start) begin
          state_nxt_s    = S_CAPTURE;
          count_nxt_s    = CW'(0);
          overflow_nxt_s = 1'b0;
          rd_ptr_nxt_s   = PW'(0);
        end else begin
          state_nxt_s    = state_r;
        end
      end
      S_CAPTURE: begin
        if (start) begin
          // Restart: a record arriving with the restart lands in slot 0.
          overflow_nxt_s = 1'b0;
          rd_ptr_nxt_s   = PW'(0);
          wr_en_s        = cap_valid;
          wr_addr_s      = PW'(0);
          count_nxt_s    = cap_valid ? CW'(1) : CW'(0);
        end else begin
          if (cap_valid) begin
            if (!full_s) begin
              wr_en_s     = 1'b1;
              count_nxt_s = count_r + CW'(1);
            end else begin
              overflow_nxt_s = 1'b1;
            end
          end else begin
            count_nxt_s = count_r;
          end
          // The decision uses the count including a record captured this cycle.
          if (stop) begin
            state_nxt_s = (count_nxt_s != CW'(0)) ? S_DUMP : S_DONE;
          end else begin
            state_nxt_s = S_CAPTURE;
          end
        end
      end
      S_DUMP: begin
        if (out_ready) begin
          if (last_s) begin
            state_nxt_s  = S_DONE;
          end else begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
          end
        end else begin
          state_nxt_s = S_DUMP;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Control registers; reset abandons any session in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      count_r    <= CW'(0);
      overflow_r <= 1'b0;
      rd_ptr_r   <= PW'(0);
    end else begin
      state_r    <= state_nxt_s;
      count_r    <= count_nxt_s;
      overflow_r <= overflow_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
    end
  end

  // Record buffer write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= cap_data;
    end
  end

endmodule

// File: tb/tb_tv_recorder.sv
// Self-checking bench for tv_recorder: a table of directed vectors for the
// main round trips, plus hand-written fill/overflow and reset-mid-dump runs.
module tb_tv_recorder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, cap_valid, out_ready;
  logic [4:0] cap_data;
  logic       out_valid, out_last, full, overflow, busy, done;
  logic [4:0] out_data;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  tv_recorder #(.W(5), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cap_valid(cap_valid), .cap_data(cap_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .count(count), .full(full), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       st, sp, cv;
    logic [4:0] cd;
    logic       rdy;
    logic       ov;
    logic [4:0] od;
    logic       ol;
    logic [4:0] cnt;
    logic       fu, of, bu, dn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, sp, cv, input logic [4:0] cd,
                              input logic rdy, ov, input logic [4:0] od,
                              input logic ol, input logic [4:0] cnt,
                              input logic fu, of, bu, dn);
    vec_t v;
    v.st = st; v.sp = sp; v.cv = cv; v.cd = cd; v.rdy = rdy;
    v.ov = ov; v.od = od; v.ol = ol; v.cnt = cnt;
    v.fu = fu; v.of = of; v.bu = bu; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs mid-cycle, then settle just after the next rising edge.
  task automatic step(input logic st, sp, cv, input logic [4:0] cd, input logic rdy);
    @(negedge clk);
    start = st; stop = sp; cap_valid = cv; cap_data = cd; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; cap_valid = 1'b0;
    cap_data = 5'd0; out_ready = 1'b0;

    // Basic round trip
    vecs.push_back(mk(1,0,0,5'b00000,0, 0,5'b00000,0,5'd0,0,0,1,0));
    vecs.push_back(mk(0,0,1,5'b00000,0, 0,5'b00000,0,5'd1,0,0,1,0));
    vecs.push_back(mk(0,0,1,5'b10011,0, 0,5'b00000,0,5'd2,0,0,1,0));
    vecs.push_back(mk(0,0,1,5'b01101,0, 0,5'b00000,0,5'd3,0,0,1,0));
    vecs.push_back(mk(0,1,0,5'b00000,0, 1,5'b00000,0,5'd3,0,0,1,0));
    vecs.push_back(mk(0,0,0,5'b00000,1, 1,5'b10011,0,5'd3,0,0,1,0));
    vecs.push_back(mk(0,0,0,5'b00000,1, 1,5'b01101,1,5'd3,0,0,1,0));
    vecs.push_back(mk(0,0,0,5'b00000,1, 0,5'b00000,0,5'd3,0,0,0,1));
    // start&&stop in DONE, then stop&&cap_valid with count 2 (cap_valid in DUMP ignored)
    vecs.push_back(mk(1,1,0,5'b00000,0, 0,5'b00000,0,5'd0,0,0,1,0));
    vecs.push_back(mk(0,0,1,5'b01010,0, 0,5'b00000,0,5'd1,0,0,1,0));
    vecs.push_back(mk(0,0,1,5'b00111,0, 0,5'b00000,0,5'd2,0,0,1,0));
    vecs.push_back(mk(0,1,1,5'b11111,0, 1,5'b01010,0,5'd3,0,0,1,0));
    vecs.push_back(mk(0,0,1,5'b10101,1, 1,5'b00111,0,5'd3,0,0,1,0));
    vecs.push_back(mk(0,0,0,5'b00000,1, 1,5'b11111,1,5'd3,0,0,1,0));
    vecs.push_back(mk(0,0,0,5'b00000,1, 0,5'b00000,0,5'd3,0,0,0,1));
    // Empty session
    vecs.push_back(mk(1,0,0,5'b00000,0, 0,5'b00000,0,5'd0,0,0,1,0));
    vecs.push_back(mk(0,1,0,5'b00000,0, 0,5'b00000,0,5'd0,0,0,0,1));
    // Restart in CAPTURE with a record and a stop on the same cycle
    vecs.push_back(mk(1,0,0,5'b00000,0, 0,5'b00000,0,5'd0,0,0,1,0));
    vecs.push_back(mk(0,0,1,5'b00001,0, 0,5'b00000,0,5'd1,0,0,1,0));
    vecs.push_back(mk(1,1,1,5'b11000,0, 0,5'b00000,0,5'd1,0,0,1,0));
    vecs.push_back(mk(0,1,0,5'b00000,0, 1,5'b11000,1,5'd1,0,0,1,0));
    vecs.push_back(mk(0,0,0,5'b00000,0, 1,5'b11000,1,5'd1,0,0,1,0));
    vecs.push_back(mk(0,0,0,5'b00000,1, 0,5'b00000,0,5'd1,0,0,0,1));
    // Backpressure: ready pattern 1,0,0,1,1,0,1 (start in DUMP ignored)
    vecs.push_back(mk(1,0,0,5'b00000,0, 0,5'b00000,0,5'd0,0,0,1,0));
    vecs.push_back(mk(0,0,1,5'b00010,0, 0,5'b00000,0,5'd1,0,0,1,0));
    vecs.push_back(mk(0,0,1,5'b00100,0, 0,5'b00000,0,5'd2,0,0,1,0));
    vecs.push_back(mk(0,0,1,5'b01000,0, 0,5'b00000,0,5'd3,0,0,1,0));
    vecs.push_back(mk(0,0,1,5'b10000,0, 0,5'b00000,0,5'd4,0,0,1,0));
    vecs.push_back(mk(0,1,0,5'b00000,0, 1,5'b00010,0,5'd4,0,0,1,0));
    vecs.push_back(mk(0,0,0,5'b00000,1, 1,5'b00100,0,5'd4,0,0,1,0));
    vecs.push_back(mk(1,0,0,5'b00000,0, 1,5'b00100,0,5'd4,0,0,1,0));
    vecs.push_back(mk(0,0,0,5'b00000,0, 1,5'b00100,0,5'd4,0,0,1,0));
    vecs.push_back(mk(0,0,0,5'b00000,1, 1,5'b01000,0,5'd4,0,0,1,0));
    vecs.push_back(mk(0,0,0,5'b00000,1, 1,5'b10000,1,5'd4,0,0,1,0));
    vecs.push_back(mk(0,0,0,5'b00000,0, 1,5'b10000,1,5'd4,0,0,1,0));
    vecs.push_back(mk(0,0,0,5'b00000,1, 0,5'b00000,0,5'd4,0,0,0,1));

    // Reset state
    #1;
    chk("reset status", {26'd0, out_valid, out_last, full, overflow, busy, done}, 32'd0);
    chk("reset count", {27'd0, count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].st, vecs[i].sp, vecs[i].cv, vecs[i].cd, vecs[i].rdy);
      chk($sformatf("vec%0d status", i),
          {26'd0, out_valid, out_last, full, overflow, busy, done},
          {26'd0, vecs[i].ov, vecs[i].ol, vecs[i].fu, vecs[i].of, vecs[i].bu, vecs[i].dn});
      chk($sformatf("vec%0d count", i), {27'd0, count}, {27'd0, vecs[i].cnt});
      if (vecs[i].ov) begin
        chk($sformatf("vec%0d out_data", i), {27'd0, out_data}, {27'd0, vecs[i].od});
      end
    end

    // Fill and overflow: 18 records 0..17 into a 16-deep buffer
    step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b0, 1'b1, 5'(i), 1'b0);
      chk($sformatf("fill%0d count", i), {27'd0, count}, (i >= 15) ? 32'd16 : 32'(i + 1));
      chk($sformatf("fill%0d full", i), {31'd0, full}, (i >= 15) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d overflow", i), {31'd0, overflow}, (i >= 16) ? 32'd1 : 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("play%0d valid", j), {31'd0, out_valid}, 32'd1);
      chk($sformatf("play%0d data", j), {27'd0, out_data}, 32'(j));
      chk($sformatf("play%0d last", j), {31'd0, out_last}, (j == 15) ? 32'd1 : 32'd0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    end
    chk("fill end done", {30'd0, done, overflow}, 32'd3);
    chk("fill end count", {27'd0, count}, 32'd16);

    // Reset mid-DUMP after one of three transfers
    step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'b00011, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'b00110, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'b01100, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    chk("pre-reset data", {26'd0, out_valid, out_data}, {26'd0, 1'b1, 5'b00110});
    out_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("midreset status", {26'd0, out_valid, out_last, full, overflow, busy, done}, 32'd0);
    chk("midreset count", {27'd0, count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    // stop in IDLE is ignored
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("idle stop", {29'd0, out_valid, busy, done}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'b10101, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("after reset dump", {25'd0, out_valid, out_last, out_data}, {25'd0, 1'b1, 1'b1, 5'b10101});
    chk("after reset count", {27'd0, count}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    chk("after reset done", {30'd0, out_valid, done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
